tx_am_insert_fsm: RTL
=====================

// Module: tx_am_insert_fsm
// PURPOSE
// - TX-side counterpart of the RX deskew/alignment path: schedules alignment-marker (AM) slots across the N_LANES PCS lanes.
// - Sits between the encoder/scrambler and the block-distribution stage.
// - Every AM_PERIOD blocks per lane, opens a group of N_LANES consecutive AM slots, one per lane, and stalls upstream data.
// - Drives the lane round-robin index for both AM blocks and data blocks, so the RX deskew sees markers on every lane in the same block position.
// PARAMETERS
// - N_LANES      20                          number of PCS lanes (round-robin distribution width)
// - AM_PERIOD    16383                       data blocks per lane between AM groups
// - NB_LANE      $clog2(N_LANES)             lane index width
// - NB_PERIOD    $clog2(AM_PERIOD)           per-lane period counter width
// PORTS
// - i_clock             in   1          system clock
// - i_reset             in   1          asynchronous, active-high reset
// - i_enable            in   1          block enable; low freezes all state
// - i_valid             in   1          block-slot strobe; state advances only when i_enable && i_valid
// - i_resync            in   1          synchronous restart to INIT (link retrain)
// - o_am_insert         out  1          current slot carries an AM block (downstream mux select)
// - o_am_group_start    out  1          current slot is the lane-0 AM slot of a group
// - o_lane_idx          out  NB_LANE    lane owning the current slot (AM or data)
// - o_tx_ready          out  1          upstream may present a data block this slot
// - o_period_count      out  NB_PERIOD  data rounds completed since the last AM group (debug)
// BEHAVIOUR
// - Clocking and reset
//   - One clock. i_reset is asynchronous and active-high.
//   - i_resync is synchronous, has priority over enable/valid, and is evaluated only when i_reset=0.
//   - "adv" = i_enable && i_valid. All registers update only on adv, except on reset or resync.
// - Reset/resync values
//   - state=INIT, lane=0, period=0.
//   - Outputs: o_am_insert=0, o_am_group_start=0, o_lane_idx=0, o_tx_ready=0, o_period_count=0.
// - States (one-hot): INIT=3'b001, AM=3'b010, DATA=3'b100.
// - INIT
//   - All outputs 0.
//   - On adv: go to AM with lane=0. The first AM slot is the next adv slot.
//   - This guarantees the RX sees markers immediately after link up.
// - AM
//   - o_am_insert=1, o_tx_ready=0, o_lane_idx=lane.
//   - o_am_group_start=1 when lane==0.
//   - On adv: lane increments.
//   - When lane==N_LANES-1: lane wraps to 0, period=0, go to DATA.
// - DATA
//   - o_am_insert=0, o_tx_ready=1, o_lane_idx=lane.
//   - On adv: lane increments.
//   - At lane wrap (lane==N_LANES-1): period increments.
//   - When lane==N_LANES-1 && period==AM_PERIOD-1: lane=0, go to AM.
//   - Exactly AM_PERIOD*N_LANES data slots occur between groups.
// - Output timing
//   - Outputs are Moore, decoded combinationally from registered state/lane/period.
//   - Zero latency: they describe the current slot.
//   - Upstream must sample o_tx_ready in the same cycle it presents data.
// - Boundary conditions
//   - i_valid=0 or i_enable=0: no state change; outputs hold, including mid-group (a partial AM group is never abandoned).
//   - Resync on the same cycle as the final AM or data wrap: resync wins, state=INIT.
//   - Async reset mid-group: outputs drop to reset values immediately, without waiting for a clock edge.
//   - Counter arithmetic is unsigned. The lane compare is against N_LANES-1, so non-power-of-2 lane counts never index >= N_LANES.
//   - An illegal one-hot state recovers to INIT on the next clock.
// STRUCTURE
// - Shared package pcs_tx_pkg:
//   - N_LANES and AM_PERIOD defaults.
//   - State encodings.
//   - Per-lane AM pattern constants, shared with the RX AM lock and deskew blocks.
// - Single module, no sub-module: one next-state process plus one registered process.
// - The lane/period counters are simple enough to inline.
// TESTING
// Bench uses AM_PERIOD=4, N_LANES=20 unless noted.
// - Startup: reset, then adv every cycle
//   -> 1 INIT cycle.
//   -> then 20 cycles with o_am_insert=1, lane 0..19, group_start only on lane 0.
//   -> then 80 cycles with tx_ready=1, lane cycling 0..19 four times.
//   -> then the next AM group.
// - Valid gaps: i_valid toggled 1,0,1,0 through an AM group
//   -> the group still spans exactly 20 adv slots.
//   -> outputs hold unchanged on i_valid=0 cycles.
// - Enable freeze: i_enable=0 for 5 cycles at DATA lane 7, period 2
//   -> lane stays 7 and period stays 2.
//   -> resumes at lane 8.
// - Resync: i_resync at DATA lane 13
//   -> next cycle INIT, outputs 0.
//   -> next adv starts an AM group at lane 0.
// - Async reset: asserted mid-AM at lane 9, between clock edges
//   -> o_am_insert=0 and o_lane_idx=0 before the next edge.
// - Default params (AM_PERIOD=16383)
//   -> exactly 327660 data slots between successive o_am_group_start pulses.

Source files
------------

// File: rtl/pcs_tx_pkg.sv
// pcs_tx_pkg: shared TX PCS defaults, FSM encodings and per-lane alignment marker patterns.
package pcs_tx_pkg;
  localparam int N_LANES_DEF   = 20;
  localparam int AM_PERIOD_DEF = 16383;
  typedef enum logic [2:0] {
    ST_INIT = 3'b001,
    ST_AM   = 3'b010,
    ST_DATA = 3'b100
  } state_e;
  // M0/M1/M2 marker bytes per lane, lane 0 in the least significant slot; also used by RX lock/deskew
  localparam logic [19:0][23:0] AM_PATTERN = {
    24'hC0F0E5, 24'h5F662A, 24'hADD6B7, 24'hC4314C, 24'h3536CD,
    24'h83C7CA, 24'h1AF8BD, 24'h5CB9B2, 24'hB99155, 24'hFD6C99,
    24'h68C9FB, 24'hA02476, 24'h7B4566, 24'h9A4A26, 24'hDD14C2,
    24'hF50709, 24'h4D957B, 24'h594BE8, 24'h9D718E, 24'hC16821
  };
endpackage

// File: rtl/tx_am_insert_fsm.sv
// tx_am_insert_fsm: schedules alignment-marker groups and round-robin lane ownership for TX blocks.
module tx_am_insert_fsm
  import pcs_tx_pkg::*;
#(
  parameter int N_LANES   = N_LANES_DEF,
  parameter int AM_PERIOD = AM_PERIOD_DEF,
  parameter int NB_LANE   = $clog2(N_LANES),
  parameter int NB_PERIOD = $clog2(AM_PERIOD)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic                 i_resync,
  output logic                 o_am_insert,
  output logic                 o_am_group_start,
  output logic [NB_LANE-1:0]   o_lane_idx,
  output logic                 o_tx_ready,
  output logic [NB_PERIOD-1:0] o_period_count
);
  state_e               state_q, state_d;
  logic [NB_LANE-1:0]   lane_q, lane_d;
  logic [NB_PERIOD-1:0] period_q, period_d;
  logic                 adv, lane_last, period_last;
  logic [NB_LANE-1:0]   lane_nxt;
  assign adv         = i_enable && i_valid;
  assign lane_last   = lane_q == NB_LANE'(N_LANES - 1);
  assign period_last = period_q == NB_PERIOD'(AM_PERIOD - 1);
  assign lane_nxt    = lane_last ? '0 : lane_q + NB_LANE'(1);
  always_comb begin
    state_d          = state_q;
    lane_d           = lane_q;
    period_d         = period_q;
    o_am_insert      = 1'b0;
    o_am_group_start = 1'b0;
    o_lane_idx       = '0;
    o_tx_ready       = 1'b0;
    o_period_count   = '0;
    case (state_q)
      ST_INIT: begin
        state_d = adv ? ST_AM : ST_INIT;
        lane_d  = '0;
      end
      ST_AM: begin
        o_am_insert      = 1'b1;
        o_am_group_start = lane_q == '0;
        o_lane_idx       = lane_q;
        o_period_count   = period_q;
        lane_d           = adv ? lane_nxt : lane_q;
        period_d         = adv && lane_last ? '0 : period_q;
        state_d          = adv && lane_last ? ST_DATA : ST_AM;
      end
      ST_DATA: begin
        o_tx_ready     = 1'b1;
        o_lane_idx     = lane_q;
        o_period_count = period_q;
        lane_d         = adv ? lane_nxt : lane_q;
        period_d       = adv && lane_last ? period_q + NB_PERIOD'(1) : period_q;
        state_d        = adv && lane_last && period_last ? ST_AM : ST_DATA;
      end
      default: begin
        state_d  = ST_INIT;
        lane_d   = '0;
        period_d = '0;
      end
    endcase
    // retrain overrides any advance, including the final slot of a group or period
    if (i_resync) begin
      state_d  = ST_INIT;
      lane_d   = '0;
      period_d = '0;
    end
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_INIT;
      lane_q   <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      period_q <= period_d;
    end
  end
endmodule
